// File: rtl/dds_pkg.sv
// dds_pkg: shared sample width, capture FSM states and trigger edge encoding.
package dds_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port record memory, synchronous read with enable.
module capture_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Only the output register is reset; the array stays free of reset so it maps to block RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC clock divider, sampler, level-crossing trigger and record capture FSM.
module adc_capture #(
    parameter int DATA_W  = dds_pkg::DATA_W,
    parameter int ADC_DIV = 4,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_clk,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    import dds_pkg::*;

    localparam int DIV_W = (ADC_DIV > 2) ? $clog2(ADC_DIV) : 1;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              adc_clk_q, adc_clk_d;
    logic [DATA_W-1:0] samp_q, samp_d;
    logic              samp_vld_q, samp_vld_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    state_e            state_q, state_d;
    logic              div_mid, div_last, trig, wr_en;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q  <= '0;
            adc_clk_q  <= 1'b0;
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_addr_q  <= '0;
            state_q    <= IDLE;
        end else begin
            div_cnt_q  <= div_cnt_d;
            adc_clk_q  <= adc_clk_d;
            samp_q     <= samp_d;
            samp_vld_q <= samp_vld_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_addr_q  <= wr_addr_d;
            state_q    <= state_d;
        end
    end

    // Data is taken on the same edge that raises adc_clk, half a period after the ADC launched it.
    always_comb begin
        div_mid    = div_cnt_q == DIV_W'(ADC_DIV / 2 - 1);
        div_last   = div_cnt_q == DIV_W'(ADC_DIV - 1);
        div_cnt_d  = div_last ? '0 : div_cnt_q + 1'b1;
        adc_clk_d  = div_mid ? 1'b1 : div_last ? 1'b0 : adc_clk_q;
        samp_d     = div_mid ? adc_data : samp_q;
        samp_vld_d = div_mid;
    end

    always_comb begin
        trig = force_trig || (prev_vld_q &&
               ((trig_edge == EDGE_RISE && prev_q < trig_level && samp_q >= trig_level) ||
                (trig_edge == EDGE_FALL && prev_q > trig_level && samp_q <= trig_level)));
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_addr_d  = wr_addr_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = ARMED;
                    prev_vld_d = 1'b0;
                    wr_addr_d  = '0;
                end
            end
            ARMED: begin
                if (samp_vld_q && trig) begin
                    wr_en     = 1'b1;
                    wr_addr_d = ADDR_W'(1);
                    state_d   = CAPTURE;
                end else if (samp_vld_q) begin
                    prev_d     = samp_q;
                    prev_vld_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (samp_vld_q) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = (wr_addr_q == ADDR_W'(DEPTH - 1)) ? DONE : CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc_clk = adc_clk_q;
    assign busy    = state_q == ARMED || state_q == CAPTURE;
    assign done    = state_q == DONE;

    capture_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr_q),
        .wr_data_i(samp_q),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: randomized scenarios checked against a record-level trigger model.
module tb_adc_capture;

    localparam int DIV   = 4;
    localparam int DEPTH = 256;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [9:0] adc_data = '0;
    logic       adc_clk;
    logic       arm = 1'b0;
    logic       force_trig = 1'b0;
    logic [9:0] trig_level = '0;
    logic       trig_edge = 1'b0;
    logic       busy, done;
    logic       rd_en = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [9:0] rd_data;

    int vectors = 0;
    int miscompares = 0;

    int         cyc = 0;
    bit         took = 1'b0;
    int         mode = 0;
    int         step = 0;
    bit         clear_on_arm = 1'b1;
    logic [9:0] mq[$];
    logic [9:0] lq[$];
    logic [9:0] rec[DEPTH];
    logic [9:0] exp_rec[DEPTH];

    adc_capture dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .adc_data  (adc_data),
        .adc_clk   (adc_clk),
        .arm       (arm),
        .force_trig(force_trig),
        .trig_level(trig_level),
        .trig_edge (trig_edge),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Sample instants come from the bench's own cycle count: the rising edge of adc_clk lands every DIV cycles.
    always @(posedge sys_clk) begin
        if (sys_rst) cyc = 0;
        else begin
            cyc++;
            if (arm && clear_on_arm) mq.delete();
            if (cyc % DIV == DIV / 2) begin
                mq.push_back(adc_data);
                took = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (took) begin
            took = 1'b0;
            case (mode)
                1: adc_data = adc_data + 10'(step);
                2: if (lq.size() > 0) adc_data = lq.pop_front();
                3: adc_data = 10'($urandom_range(0, 1023));
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_stream(input int m, input logic [9:0] first, input int st);
        mode = m;
        step = st;
        adc_data = first;
        took = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_all();
        rd_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a);
            tick();
            rec[a] = rd_data;
        end
        rd_en = 1'b0;
    endtask

    // Record = the DEPTH samples starting at the first sample that satisfies the trigger rule.
    task automatic build_expected(input bit frc, input logic ed, input logic [9:0] lvl, output bit found);
        bit hit;
        found = 1'b0;
        for (int i = 0; i + DEPTH <= mq.size(); i++) begin
            hit = frc || (i > 0 && (ed ? (mq[i-1] > lvl && mq[i] <= lvl)
                                       : (mq[i-1] < lvl && mq[i] >= lvl)));
            if (hit) begin
                for (int j = 0; j < DEPTH; j++) exp_rec[j] = mq[i+j];
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic first_diff(output int bad);
        bad = -1;
        for (int j = 0; j < DEPTH; j++)
            if (bad < 0 && rec[j] !== exp_rec[j]) bad = j;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if ({adc_clk, busy, done, rd_data} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: got clk/busy/done/rd=%b/%b/%b/%0d want 0/0/0/0", adc_clk, busy, done, rd_data);
        end
    endtask

    task automatic test_divider();
        sys_rst = 1'b0;
        vectors++;
        if (adc_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL div_k0: got %b want 0", adc_clk);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            vectors++;
            if (adc_clk !== logic'(k % DIV >= DIV / 2)) begin
                miscompares++;
                $display("FAIL div_k%0d: got %b want %b", k, adc_clk, k % DIV >= DIV / 2);
            end
        end
    endtask

    task automatic test_rising();
        bit ok, found;
        int bad;
        trig_level = 10'd512;
        trig_edge = 1'b0;
        start_stream(1, 10'd500, 5);
        pulse_arm();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rise_busy: got %b want 1", busy);
        end
        wait_done(ok);
        vectors++;
        if (!ok || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_done: got done=%b busy=%b want 1/0", done, busy);
        end
        build_expected(1'b0, 1'b0, 10'd512, found);
        read_all();
        first_diff(bad);
        vectors++;
        if (rec[0] !== 10'd515 || rec[1] !== 10'd520 || rec[255] !== 10'd766) begin
            miscompares++;
            $display("FAIL rise_values: got %0d,%0d,%0d want 515,520,766", rec[0], rec[1], rec[255]);
        end
        vectors++;
        if (!found || bad >= 0) begin
            miscompares++;
            $display("FAIL rise_record: found=%b idx %0d got %0d want %0d", found, bad, rec[bad < 0 ? 0 : bad], exp_rec[bad < 0 ? 0 : bad]);
        end
    endtask

    task automatic test_readout();
        logic [9:0] want[3] = '{10'd515, 10'd520, 10'd766};
        logic [7:0] addrs[3] = '{8'd0, 8'd1, 8'd255};
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = addrs[i];
            tick();
            vectors++;
            if (rd_data !== want[i]) begin
                miscompares++;
                $display("FAIL read_addr%0d: got %0d want %0d", addrs[i], rd_data, want[i]);
            end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 8'($urandom_range(0, 255));
            tick();
            vectors++;
            if (rd_data !== 10'd766) begin
                miscompares++;
                $display("FAIL read_hold%0d: got %0d want 766", i, rd_data);
            end
        end
    endtask

    task automatic test_falling();
        bit ok;
        trig_level = 10'd300;
        trig_edge = 1'b1;
        lq.delete();
        repeat (9) lq.push_back(10'd290);
        lq.push_back(10'd310);
        lq.push_back(10'd305);
        lq.push_back(10'd300);
        start_stream(2, 10'd290, 0);
        pulse_arm();
        repeat (5 * DIV) tick();
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_no_early_trig: got busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(ok);
        read_all();
        vectors++;
        if (!ok || rec[0] !== 10'd300 || rec[255] !== 10'd300) begin
            miscompares++;
            $display("FAIL fall_record: done=%b got %0d..%0d want 300..300", ok, rec[0], rec[255]);
        end
    endtask

    task automatic test_force();
        bit ok;
        int bad;
        trig_level = 10'd512;
        trig_edge = 1'b0;
        force_trig = 1'b1;
        start_stream(0, 10'd100, 0);
        pulse_arm();
        wait_done(ok);
        force_trig = 1'b0;
        read_all();
        for (int j = 0; j < DEPTH; j++) exp_rec[j] = 10'd100;
        first_diff(bad);
        vectors++;
        if (!ok || done !== 1'b1 || bad >= 0) begin
            miscompares++;
            $display("FAIL force_record: done=%b idx %0d got %0d want 100", done, bad, rec[bad < 0 ? 0 : bad]);
        end
    endtask

    task automatic test_random();
        bit ok, found;
        int bad;
        for (int it = 0; it < 3; it++) begin
            trig_level = 10'($urandom_range(100, 900));
            trig_edge = 1'($urandom_range(0, 1));
            start_stream(3, 10'($urandom_range(0, 1023)), 0);
            pulse_arm();
            wait_done(ok);
            build_expected(1'b0, trig_edge, trig_level, found);
            read_all();
            first_diff(bad);
            vectors++;
            if (!ok || !found || bad >= 0) begin
                miscompares++;
                $display("FAIL random%0d: done=%b found=%b idx %0d got %0d want %0d", it, ok, found, bad, rec[bad < 0 ? 0 : bad], exp_rec[bad < 0 ? 0 : bad]);
            end
        end
    endtask

    task automatic test_arm_during_capture();
        bit ok, found;
        int bad;
        force_trig = 1'b1;
        start_stream(1, 10'($urandom_range(0, 1023)), 3);
        pulse_arm();
        repeat (200) tick();
        clear_on_arm = 1'b0;
        pulse_arm();
        clear_on_arm = 1'b1;
        force_trig = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm_busy: got busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(ok);
        build_expected(1'b1, 1'b0, 10'd0, found);
        read_all();
        first_diff(bad);
        vectors++;
        if (!ok || !found || bad >= 0) begin
            miscompares++;
            $display("FAIL rearm_record: done=%b idx %0d got %0d want %0d", ok, bad, rec[bad < 0 ? 0 : bad], exp_rec[bad < 0 ? 0 : bad]);
        end
    endtask

    task automatic test_reset_mid_capture();
        bit ok, found;
        int bad;
        force_trig = 1'b1;
        start_stream(1, 10'($urandom_range(0, 1023)), 7);
        pulse_arm();
        for (int i = 0; i < 2000 && mq.size() < 100; i++) tick();
        tick();
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || adc_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: got busy=%b done=%b clk=%b want 0/0/0", busy, done, adc_clk);
        end
        tick();
        tick();
        sys_rst = 1'b0;
        repeat (3 * DIV) tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: got busy=%b done=%b want 0/0", busy, done);
        end
        pulse_arm();
        wait_done(ok);
        force_trig = 1'b0;
        build_expected(1'b1, 1'b0, 10'd0, found);
        read_all();
        first_diff(bad);
        vectors++;
        if (!ok || !found || bad >= 0) begin
            miscompares++;
            $display("FAIL midrst_record: done=%b idx %0d got %0d want %0d", ok, bad, rec[bad < 0 ? 0 : bad], exp_rec[bad < 0 ? 0 : bad]);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_rising();
        test_readout();
        test_falling();
        test_force();
        test_random();
        test_arm_during_capture();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
